hazard_stall_unit: RTL and testbench



---
 rtl/pipe_pkg.sv | 21 ++
 rtl/hazard_stall_unit_if.sv | 38 +++
 rtl/hazard_stall_unit_sat_counter.sv | 20 ++
 rtl/hazard_stall_unit.sv | 112 +++++++++++
 tb/tb_hazard_stall_unit.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: register/opcode widths, opcode map and the
// hazard interlock state type.
package pipe_pkg;

    localparam int REG_ADDR_W = 3;
    localparam int OPCODE_W   = 4;

    localparam logic [OPCODE_W-1:0] OP_ADD      = 4'b0000;
    localparam logic [OPCODE_W-1:0] OP_SUB      = 4'b0001;
    localparam logic [OPCODE_W-1:0] OP_ADDI     = 4'b1000;
    localparam logic [OPCODE_W-1:0] LOAD_OPCODE = 4'b1011;
    localparam logic [OPCODE_W-1:0] OP_SB       = 4'b1111;
    localparam logic [OPCODE_W-1:0] OP_BEQ      = 4'b0100;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MEM_WAIT   = 2'd2
    } hz_state_t;

endpackage

// File: rtl/hazard_stall_unit_if.sv
// Bundle between the pipeline datapath (master) and the hazard interlock (slave).
interface hazard_stall_unit_if
    import pipe_pkg::*;
#(
    parameter int STALL_CNT_W = 16
);
    logic [REG_ADDR_W-1:0]  id_rs;
    logic [REG_ADDR_W-1:0]  id_rt;
    logic                   id_uses_rt;
    logic [REG_ADDR_W-1:0]  idex_rd;
    logic [OPCODE_W-1:0]    idex_opcode;
    logic                   idex_reg_write;
    logic                   ex_branch_taken;
    logic                   mem_req;
    logic                   mem_ready;
    logic                   pc_write;
    logic                   ifid_write;
    logic                   ifid_flush;
    logic                   idex_write;
    logic                   idex_bubble;
    logic                   exmem_hold;
    logic                   mem_timeout;
    logic [STALL_CNT_W-1:0] stall_count;

    modport master (
        output id_rs, id_rt, id_uses_rt, idex_rd, idex_opcode, idex_reg_write,
               ex_branch_taken, mem_req, mem_ready,
        input  pc_write, ifid_write, ifid_flush, idex_write, idex_bubble,
               exmem_hold, mem_timeout, stall_count
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, idex_rd, idex_opcode, idex_reg_write,
               ex_branch_taken, mem_req, mem_ready,
        output pc_write, ifid_write, ifid_flush, idex_write, idex_bubble,
               exmem_hold, mem_timeout, stall_count
    );
endinterface

// File: rtl/hazard_stall_unit_sat_counter.sv
// Saturating up-counter with enable and asynchronous active-low clear.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    // Count enabled cycles, sticking at all-ones.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/hazard_stall_unit.sv
// Pipeline interlock: load-use bubbles, taken-branch flushes and data-memory
// freezes, plus a stall-cycle counter and a memory wait timeout monitor.
module hazard_stall_unit
    import pipe_pkg::*;
#(
    parameter logic [OPCODE_W-1:0] LOAD_OPCODE = pipe_pkg::LOAD_OPCODE,
    parameter int                  MEM_TIMEOUT = 16,
    parameter int                  STALL_CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    hazard_stall_unit_if.slave hz
);

    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    hz_state_t              state;
    logic [7:0]             wait_cnt;
    logic                   mem_timeout_q;
    logic                   mem_stall;
    logic                   load_use;
    logic                   pc_write_c;
    logic [STALL_CNT_W-1:0] stall_cnt;

    assign mem_stall = hz.mem_req & ~hz.mem_ready;
    assign load_use  = (hz.idex_opcode == LOAD_OPCODE) & hz.idex_reg_write &
                       ((hz.idex_rd == hz.id_rs) |
                        (hz.id_uses_rt & (hz.idex_rd == hz.id_rt)));

    // Prioritised pipeline register controls, effective in the current cycle.
    always_comb begin
        pc_write_c     = 1'b1;
        hz.ifid_write  = 1'b1;
        hz.idex_write  = 1'b1;
        hz.ifid_flush  = 1'b0;
        hz.idex_bubble = 1'b0;
        hz.exmem_hold  = 1'b0;
        if (!rst_n) begin
            pc_write_c     = 1'b0;
            hz.ifid_write  = 1'b0;
            hz.idex_write  = 1'b0;
            hz.ifid_flush  = 1'b1;
            hz.idex_bubble = 1'b1;
        end else if (mem_stall) begin
            pc_write_c     = 1'b0;
            hz.ifid_write  = 1'b0;
            hz.idex_write  = 1'b0;
            hz.exmem_hold  = 1'b1;
        end else if (hz.ex_branch_taken) begin
            hz.ifid_flush  = 1'b1;
            hz.idex_bubble = 1'b1;
        end else if (load_use && (state == RUN)) begin
            pc_write_c     = 1'b0;
            hz.ifid_write  = 1'b0;
            hz.idex_bubble = 1'b1;
        end
    end

    assign hz.pc_write    = pc_write_c;
    assign hz.mem_timeout = mem_timeout_q;
    assign hz.stall_count = stall_cnt;

    // Interlock FSM with the memory wait counter and registered timeout pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= RUN;
            wait_cnt      <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            mem_timeout_q <= 1'b0;
            case (state)
                RUN: begin
                    if (mem_stall) begin
                        state <= MEM_WAIT;
                    end else if (load_use && !hz.ex_branch_taken) begin
                        state <= LOAD_STALL;
                    end
                end
                LOAD_STALL: begin
                    state <= mem_stall ? MEM_WAIT : RUN;
                end
                MEM_WAIT: begin
                    if (mem_stall) begin
                        if (wait_cnt == WAIT_LAST) begin
                            wait_cnt      <= '0;
                            mem_timeout_q <= 1'b1;
                        end else begin
                            wait_cnt <= wait_cnt + 8'd1;
                        end
                    end else begin
                        state    <= RUN;
                        wait_cnt <= '0;
                    end
                end
                default: begin
                    state    <= RUN;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

    sat_counter #(
        .WIDTH (STALL_CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .clr_n (rst_n),
        .en    (~pc_write_c),
        .count (stall_cnt)
    );

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Self-checking bench for hazard_stall_unit: directed vector table, hand
// sequences for timeout/reset/saturation, and random stimulus vs a model.
module tb_hazard_stall_unit;
    import pipe_pkg::*;

    localparam int SW  = 6;
    localparam int MT  = 4;
    localparam int SAT = (1 << SW) - 1;
    localparam logic [3:0] LD = 4'hB;
    localparam logic [3:0] NP = 4'h0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    hazard_stall_unit_if #(.STALL_CNT_W(SW)) hz ();

    hazard_stall_unit #(
        .LOAD_OPCODE (4'b1011),
        .MEM_TIMEOUT (MT),
        .STALL_CNT_W (SW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [2:0] rs, rt;
        logic       urt;
        logic [2:0] rd;
        logic [3:0] opc;
        logic       rw, br, req, rdy;
        logic       pc, ifw, fl, idw, bub, hold, tmo;
        int         cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [2:0] rs, input logic [2:0] rt, input logic urt,
                                input logic [2:0] rd, input logic [3:0] opc, input logic rw,
                                input logic br, input logic req, input logic rdy,
                                input logic pc, input logic ifw, input logic fl, input logic idw,
                                input logic bub, input logic hold, input logic tmo, input int cnt);
        vec_t v;
        v.rs = rs; v.rt = rt; v.urt = urt; v.rd = rd; v.opc = opc; v.rw = rw;
        v.br = br; v.req = req; v.rdy = rdy;
        v.pc = pc; v.ifw = ifw; v.fl = fl; v.idw = idw; v.bub = bub; v.hold = hold;
        v.tmo = tmo; v.cnt = cnt;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic pc, input logic ifw, input logic fl,
                            input logic idw, input logic bub, input logic hold, input logic tmo,
                            input int cnt);
        chk({tag, ".pc_write"},    int'(hz.pc_write),    int'(pc));
        chk({tag, ".ifid_write"},  int'(hz.ifid_write),  int'(ifw));
        chk({tag, ".ifid_flush"},  int'(hz.ifid_flush),  int'(fl));
        chk({tag, ".idex_write"},  int'(hz.idex_write),  int'(idw));
        chk({tag, ".idex_bubble"}, int'(hz.idex_bubble), int'(bub));
        chk({tag, ".exmem_hold"},  int'(hz.exmem_hold),  int'(hold));
        chk({tag, ".mem_timeout"}, int'(hz.mem_timeout), int'(tmo));
        chk({tag, ".stall_count"}, int'(hz.stall_count), cnt);
    endtask

    task automatic drive(input logic [2:0] rs, input logic [2:0] rt, input logic urt,
                         input logic [2:0] rd, input logic [3:0] opc, input logic rw,
                         input logic br, input logic req, input logic rdy);
        hz.id_rs = rs; hz.id_rt = rt; hz.id_uses_rt = urt; hz.idex_rd = rd;
        hz.idex_opcode = opc; hz.idex_reg_write = rw; hz.ex_branch_taken = br;
        hz.mem_req = req; hz.mem_ready = rdy;
    endtask

    task automatic drive_nop();
        drive(3'd0, 3'd0, 1'b0, 3'd3, NP, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    // Assert reset, check forced outputs at once, then release on a falling edge.
    task automatic do_reset(input string tag);
        drive_nop();
        rst_n = 1'b0;
        #1;
        chk_outs(tag, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Reference model state: behaviour described in terms of past cycles.
    bit m_prev_stall;
    bit m_prev_bubble;
    int m_run_len;
    int m_cnt;

    task automatic model_clear();
        m_prev_stall = 0; m_prev_bubble = 0; m_run_len = 0; m_cnt = 0;
    endtask

    initial begin
        vec_t v;
        logic [2:0] rs, rt, rd;
        logic [3:0] opc;
        logic urt, rw, br, req, rdy;
        bit   stall, lu, run_ok, bubble;
        logic e_pc, e_ifw, e_fl, e_idw, e_bub, e_hold, e_tmo;

        // rs  rt  urt rd  opc rw br req rdy | pc ifw fl idw bub hold tmo cnt
        tbl.push_back(mk(3, 0, 0, 3, LD, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(3, 0, 0, 3, LD, 1, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 1));
        tbl.push_back(mk(5, 3, 0, 3, LD, 1, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 1));
        tbl.push_back(mk(5, 3, 1, 3, LD, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1));
        tbl.push_back(mk(3, 3, 1, 3, NP, 1, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 2));
        tbl.push_back(mk(3, 0, 0, 3, LD, 1, 1, 0, 0, 1, 1, 1, 1, 1, 0, 0, 2));
        tbl.push_back(mk(3, 0, 0, 3, LD, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 2));
        tbl.push_back(mk(0, 0, 0, 3, NP, 1, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 3));
        tbl.push_back(mk(3, 0, 0, 3, LD, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 3));
        tbl.push_back(mk(0, 0, 0, 3, NP, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 3));
        tbl.push_back(mk(0, 0, 0, 3, NP, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 4));
        tbl.push_back(mk(0, 0, 0, 3, NP, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 5));
        tbl.push_back(mk(0, 0, 0, 3, NP, 1, 0, 1, 1, 1, 1, 0, 1, 0, 0, 0, 6));
        tbl.push_back(mk(0, 0, 0, 3, NP, 1, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 6));
        tbl.push_back(mk(0, 0, 0, 3, NP, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 6));
        tbl.push_back(mk(0, 0, 0, 3, NP, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 7));
        tbl.push_back(mk(0, 0, 0, 3, NP, 1, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 7));
        tbl.push_back(mk(3, 0, 0, 3, LD, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 7));
        tbl.push_back(mk(0, 0, 0, 3, NP, 1, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 8));
        tbl.push_back(mk(0, 0, 0, 3, NP, 1, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 8));
        tbl.push_back(mk(0, 0, 0, 3, NP, 1, 0, 1, 1, 1, 1, 0, 1, 0, 0, 0, 8));
        tbl.push_back(mk(1, 3, 1, 3, LD, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 8));
        tbl.push_back(mk(0, 0, 0, 3, NP, 1, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 9));

        #3;
        do_reset("reset0");
        foreach (tbl[i]) begin
            v = tbl[i];
            @(posedge clk); #1;
            drive(v.rs, v.rt, v.urt, v.rd, v.opc, v.rw, v.br, v.req, v.rdy);
            @(negedge clk);
            chk_outs($sformatf("tbl%0d", i), v.pc, v.ifw, v.fl, v.idw, v.bub, v.hold, v.tmo, v.cnt);
        end

        // Timeout: ten waiting cycles, pulses on the 5th and 9th cycle in MEM_WAIT.
        do_reset("reset1");
        for (int i = 1; i <= 11; i++) begin
            @(posedge clk); #1;
            drive(3'd0, 3'd0, 1'b0, 3'd3, NP, 1'b1, 1'b0, 1'b1, (i == 11) ? 1'b1 : 1'b0);
            @(negedge clk);
            if (i <= 10)
                chk_outs($sformatf("tmo%0d", i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                         (i == 6 || i == 10) ? 1'b1 : 1'b0, i - 1);
            else
                chk_outs("tmo_release", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10);
        end

        // Reset asserted in the middle of a memory wait.
        do_reset("reset2");
        repeat (3) begin
            @(posedge clk); #1;
            drive(3'd0, 3'd0, 1'b0, 3'd3, NP, 1'b1, 1'b0, 1'b1, 1'b0);
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk_outs("rst_mid", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        drive_nop();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        drive(3'd3, 3'd0, 1'b0, 3'd3, LD, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk_outs("rst_after", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0);

        // Long wait saturates the stall counter.
        do_reset("reset3");
        repeat (70) begin
            @(posedge clk); #1;
            drive(3'd0, 3'd0, 1'b0, 3'd3, NP, 1'b1, 1'b0, 1'b1, 1'b0);
        end
        @(posedge clk); #1;
        drive_nop();
        @(negedge clk);
        chk("sat.stall_count", int'(hz.stall_count), SAT);
        chk("sat.pc_write", int'(hz.pc_write), 1);

        // Random stimulus against the reference model.
        do_reset("reset4");
        model_clear();
        for (int n = 0; n < 500; n++) begin
            rs  = 3'($urandom_range(0, 3));
            rt  = 3'($urandom_range(0, 3));
            rd  = 3'($urandom_range(0, 3));
            urt = 1'($urandom_range(0, 1));
            opc = ($urandom_range(0, 1) == 1) ? LD : 4'($urandom_range(0, 15));
            rw  = ($urandom_range(0, 3) != 0);
            br  = ($urandom_range(0, 4) == 0);
            req = ($urandom_range(0, 2) == 0);
            rdy = ($urandom_range(0, 3) == 0);
            @(posedge clk); #1;
            drive(rs, rt, urt, rd, opc, rw, br, req, rdy);

            stall  = req && !rdy;
            lu     = (opc == LD) && rw && ((rd == rs) || (urt && rd == rt));
            run_ok = !m_prev_stall && !m_prev_bubble;
            bubble = !stall && !br && lu && run_ok;
            e_pc   = !(stall || bubble);
            e_ifw  = e_pc;
            e_idw  = !stall;
            e_fl   = !stall && br;
            e_bub  = !stall && (br || bubble);
            e_hold = stall;
            e_tmo  = (m_run_len > 1) && (((m_run_len - 1) % MT) == 0);

            @(negedge clk);
            chk_outs($sformatf("rnd%0d", n), e_pc, e_ifw, e_fl, e_idw, e_bub, e_hold, e_tmo, m_cnt);

            if (!e_pc && m_cnt < SAT) m_cnt++;
            m_run_len     = stall ? m_run_len + 1 : 0;
            m_prev_stall  = stall;
            m_prev_bubble = bubble;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
